dlsc_pcie_s6_inbound_read_cpl_gen: RTL and testbench
====================================================

DLSC_PCIE_S6_INBOUND_READ_CPL_GEN -- requirements
Module: dlsc_pcie_s6_inbound_read_cpl_gen

Interface
REQ-001 Parameter: none; all sizing is fixed by the PCIe 3DW completion format.
REQ-002 clk  input  1  clock; all logic is rising-edge clocked.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_ready out 1 / req_valid in 1  accepted-read-request handshake.
REQ-005 req_id in 16, req_tag in 8, req_tc in 3, req_attr in 2  requester fields, echoed into the completions.
REQ-006 req_len in 10  read length in DWORDs; 0 means 1024.
REQ-007 req_addr in 7 [8:2]  low DWORD address of the request.
REQ-008 rd_ready out 1 / rd_valid in 1 / rd_data in 32 / rd_last in 1 / rd_resp in 2  read-data stream from the AXI master, exactly req_len beats per request.
REQ-009 tx_ready in 1 / tx_valid out 1 / tx_data out 32 / tx_last out 1  completion TLP stream.
REQ-010 cfg_rcb in 1 (0=64B, 1=128B); cfg_max_payload in 3 (0=128B, 1=256B, 2=512B, others treated as 512B); cfg_completer_id in 16.
REQ-011 cpl_done out 1  single-cycle pulse when a request's final completion word is accepted.

Function
REQ-012 States: ST_IDLE, ST_H0, ST_H1, ST_H2, ST_DATA, ST_DRAIN.
REQ-013 ST_IDLE: req_ready=1; on req_valid, capture the request, set rem=req_len (1024 if 0) and addr=req_addr, set poison=0, then enter ST_H0.
REQ-014 ST_H0 waits for rd_valid without consuming the beat; tx_valid=0 until then.
REQ-015 When the first beat of a request has rd_resp!=OKAY, send one Cpl without data: status UR for DECERR, CA for SLVERR, fmt=00, length=0.
REQ-016 After that header, go to ST_DRAIN, which consumes rd beats through rd_last with tx idle, then goes to ST_IDLE and pulses cpl_done.
REQ-017 Segment length seg = min(rem, MPS_dw - (addr mod MPS_dw)), where MPS_dw = 32/64/128.
REQ-018 Every split point is therefore MPS-aligned and hence RCB-aligned; cfg_rcb is informational only.
REQ-019 H0 word: [30:29]=10, [28:24]=01010, [22:20]=tc, [14]=poison, [13:12]=attr, [9:0]=seg (1024 encodes as 0).
REQ-020 H1 word: [31:16]=completer_id, [15:13]=status (000 SC), [12]=0, [11:0]=4*rem bytes (4096 encodes as 0).
REQ-021 H2 word: [31:16]=req_id, [15:8]=tag, [7]=0, [6:0]={addr[6:2],2'b00}.
REQ-022 A header word advances only on tx_ready&&tx_valid.
REQ-023 ST_DATA: tx_valid=rd_valid and rd_ready=tx_ready, combinationally.
REQ-024 ST_DATA: tx_data is byte-swapped rd_data, i.e. {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}.
REQ-025 ST_DATA: tx_last is asserted on the seg-th beat.
REQ-026 Each accepted data beat decrements rem and increments addr; the 7-bit addr wraps silently.
REQ-027 At segment end: if rem=0 go to ST_IDLE and pulse cpl_done; otherwise go to ST_H0 for the next segment.
REQ-028 A beat with rd_resp!=OKAY after the first is forwarded normally but sets poison=1, so every later segment of that request has EP=1.
REQ-029 If rd_last arrives before the expected beat count, or is missing at the final beat, that is a protocol violation; behaviour is undefined and flagged by simulation assertion only.
REQ-030 Back-to-back requests are supported: req_ready may assert in the cycle after cpl_done.
REQ-031 Latency: first header word is valid one cycle after rd_valid is seen in ST_H0.
REQ-032 Throughput: one word per cycle when tx_ready and rd_valid are held high.

Reset
REQ-033 On rst: state ST_IDLE, tx_valid=0, tx_last=0, rd_ready=0, req_ready=1 (combinational from state), cpl_done=0, poison=0, rem=0, addr=0.
REQ-034 rst mid-TLP abandons the TLP immediately; no further words are emitted.

Structure
REQ-035 TLP fmt/type constants, completion status codes and AXI resp codes go in shared package dlsc_pcie_s6_pkg, next to the constants the outbound completion receiver already uses.
REQ-036 Sub-module dlsc_pcie_s6_cpl_seg_calc is a combinational block computing seg and the encoded byte count from rem, addr and cfg_max_payload.

Verification
REQ-037 req_len=4, addr=0x00, MPS=128B, all OKAY -> one CplD: length=4, bytecount=16, lower addr 0x00, 7 words, tx_last on word 7.
REQ-038 req_len=40, addr=0x1C (DW), MPS=128B -> segs of 4, 32 and 4 DW; bytecounts 160, 144 and 16; lower addrs 0x70, 0x00 and 0x00.
REQ-039 req_len=8, first beat DECERR -> single 3-word Cpl with status UR, length 0; 8 rd beats drained; one cpl_done pulse.
REQ-040 req_len=64, MPS=128B, beat 10 SLVERR -> seg1 EP=0, seg2 EP=1; all 64 data words forwarded.
REQ-041 Random tx_ready/rd_valid throttling with req_len=0 (1024 DW) at MPS=512B -> 8 segments; first bytecount encoded 0 (4096); data matches a byte-swapped reference queue.
REQ-042 rst asserted in ST_DATA -> tx_valid low next cycle; next request completes correctly.

Source files
------------

// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared PCIe/AXI constants and types for the Spartan-6 PCIe bridge.
// Completion TLP encodings, AXI response codes, completion generator types.
package dlsc_pcie_s6_pkg;

   localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
   localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
   localparam logic [4:0] TYPE_CPL       = 5'b01010;

   localparam logic [2:0] CPL_SC = 3'b000;
   localparam logic [2:0] CPL_UR = 3'b001;
   localparam logic [2:0] CPL_CA = 3'b100;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_H0,
      ST_H1,
      ST_H2,
      ST_DATA,
      ST_DRAIN
   } cpl_state_t;

   typedef struct packed {
      logic [15:0] id;
      logic [7:0]  tag;
      logic [2:0]  tc;
      logic [1:0]  attr;
   } cpl_req_t;

   // Max payload in DWORDs; reserved encodings fall back to 512B.
   function automatic logic [7:0] mps_dw(input logic [2:0] mps);
      unique case (mps)
         3'd0:    return 8'd32;
         3'd1:    return 8'd64;
         default: return 8'd128;
      endcase
   endfunction

endpackage

// File: rtl/dlsc_pcie_s6_inbound_read_cpl_gen_if.sv
// Handshake bundle for the inbound read completion generator.
// Request, AXI read-data and completion TLP streams.
interface dlsc_pcie_s6_inbound_read_cpl_gen_if;

   logic        req_ready;
   logic        req_valid;
   logic [15:0] req_id;
   logic [7:0]  req_tag;
   logic [2:0]  req_tc;
   logic [1:0]  req_attr;
   logic [9:0]  req_len;
   logic [6:0]  req_addr;

   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;
   logic [1:0]  rd_resp;

   logic        tx_ready;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_last;

   modport master (
      input  req_ready,
      output req_valid, req_id, req_tag, req_tc,
      output req_attr, req_len, req_addr,
      input  rd_ready,
      output rd_valid, rd_data, rd_last, rd_resp,
      output tx_ready,
      input  tx_valid, tx_data, tx_last
   );

   modport slave (
      output req_ready,
      input  req_valid, req_id, req_tag, req_tc,
      input  req_attr, req_len, req_addr,
      output rd_ready,
      input  rd_valid, rd_data, rd_last, rd_resp,
      input  tx_ready,
      output tx_valid, tx_data, tx_last
   );

endinterface

// File: rtl/dlsc_pcie_s6_cpl_seg_calc.sv
// Completion segment sizing: splits a read at max-payload boundaries.
// Also yields the remaining byte count (4096 wraps to 0).
module dlsc_pcie_s6_cpl_seg_calc
   import dlsc_pcie_s6_pkg::*;
(
   input  logic [10:0] rem,
   input  logic [6:0]  addr,
   input  logic [2:0]  cfg_max_payload,
   output logic [9:0]  seg,
   output logic [11:0] byte_cnt
);

   logic [7:0] mps;
   logic [7:0] off;
   logic [7:0] lim;

   // Distance to the next payload boundary, clipped to what is left.
   always_comb begin
      mps = mps_dw(cfg_max_payload);
      off = {1'b0, addr} & (mps - 8'd1);
      lim = mps - off;
      if (rem < {3'b000, lim}) begin
         seg = rem[9:0];
      end else begin
         seg = {2'b00, lim};
      end
      byte_cnt = {rem[9:0], 2'b00};
   end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_read_cpl_gen.sv
// Inbound read completion generator: turns AXI read data into CplD TLPs.
// Splits on max-payload boundaries and reports AXI errors as UR/CA/EP.
module dlsc_pcie_s6_inbound_read_cpl_gen
   import dlsc_pcie_s6_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   dlsc_pcie_s6_inbound_read_cpl_gen_if.slave bus,
   input  logic        cfg_rcb,
   input  logic [2:0]  cfg_max_payload,
   input  logic [15:0] cfg_completer_id,
   output logic        cpl_done
);

   cpl_state_t  state;
   cpl_state_t  state_nx;
   cpl_req_t    req;
   logic [10:0] rem;
   logic [6:0]  addr;
   logic [9:0]  seg_cnt;
   logic        poison;
   logic        armed;
   logic        first;
   logic        err;
   logic [2:0]  err_sts;

   logic [9:0]  seg;
   logic [11:0] byte_cnt;
   logic [31:0] w0;
   logic [31:0] w1;
   logic [31:0] w2;
   logic        dat_acc;

   logic        tx_valid_c;
   logic [31:0] tx_data_c;
   logic        tx_last_c;
   logic        rd_ready_c;
   logic        done_c;

   dlsc_pcie_s6_cpl_seg_calc u_seg (
      .rem             (rem),
      .addr            (addr),
      .cfg_max_payload (cfg_max_payload),
      .seg             (seg),
      .byte_cnt        (byte_cnt)
   );

   assign w0 = {1'b0, err ? FMT_3DW_NODATA : FMT_3DW_DATA,
                TYPE_CPL, 1'b0, req.tc, 4'h0, 1'b0, poison,
                req.attr, 2'b00, err ? 10'd0 : seg};
   assign w1 = {cfg_completer_id, err ? err_sts : CPL_SC,
                1'b0, byte_cnt};
   assign w2 = {req.id, req.tag, 1'b0, addr[4:0], 2'b00};

   assign dat_acc = (state == ST_DATA) && bus.rd_valid
                    && bus.tx_ready;

   // Next state and stream outputs; data phase is a pass-through.
   always_comb begin
      state_nx   = state;
      tx_valid_c = 1'b0;
      tx_data_c  = 32'd0;
      tx_last_c  = 1'b0;
      rd_ready_c = 1'b0;
      done_c     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.req_valid) state_nx = ST_H0;
         end
         ST_H0: begin
            tx_valid_c = armed;
            tx_data_c  = w0;
            if (armed && bus.tx_ready) state_nx = ST_H1;
         end
         ST_H1: begin
            tx_valid_c = 1'b1;
            tx_data_c  = w1;
            if (bus.tx_ready) state_nx = ST_H2;
         end
         ST_H2: begin
            tx_valid_c = 1'b1;
            tx_data_c  = w2;
            tx_last_c  = err;
            if (bus.tx_ready)
               state_nx = err ? ST_DRAIN : ST_DATA;
         end
         ST_DATA: begin
            tx_valid_c = bus.rd_valid;
            rd_ready_c = bus.tx_ready;
            tx_data_c  = {bus.rd_data[7:0], bus.rd_data[15:8],
                          bus.rd_data[23:16], bus.rd_data[31:24]};
            tx_last_c  = (seg_cnt == 10'd1);
            if (dat_acc && seg_cnt == 10'd1) begin
               done_c   = (rem == 11'd1);
               state_nx = (rem == 11'd1) ? ST_IDLE : ST_H0;
            end
         end
         ST_DRAIN: begin
            rd_ready_c = 1'b1;
            if (bus.rd_valid && bus.rd_last) begin
               done_c   = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (rst) begin
         tx_valid_c = 1'b0;
         tx_last_c  = 1'b0;
         rd_ready_c = 1'b0;
         done_c     = 1'b0;
      end
   end

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.tx_valid  = tx_valid_c;
   assign bus.tx_data   = tx_data_c;
   assign bus.tx_last   = tx_last_c;
   assign bus.rd_ready  = rd_ready_c;
   assign cpl_done      = done_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Request capture, segment bookkeeping and error tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         req     <= '0;
         rem     <= 11'd0;
         addr    <= 7'd0;
         seg_cnt <= 10'd0;
         poison  <= 1'b0;
         armed   <= 1'b0;
         first   <= 1'b0;
         err     <= 1'b0;
         err_sts <= CPL_SC;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  req.id   <= bus.req_id;
                  req.tag  <= bus.req_tag;
                  req.tc   <= bus.req_tc;
                  req.attr <= bus.req_attr;
                  rem      <= (bus.req_len == 10'd0) ? 11'd1024
                              : {1'b0, bus.req_len};
                  addr     <= bus.req_addr;
                  poison   <= 1'b0;
                  first    <= 1'b1;
                  err      <= 1'b0;
               end
            end
            ST_H0: begin
               if (!armed && bus.rd_valid) begin
                  armed   <= 1'b1;
                  err     <= first && (bus.rd_resp != AXI_OKAY);
                  err_sts <= (bus.rd_resp == AXI_DECERR)
                             ? CPL_UR : CPL_CA;
               end else if (armed && bus.tx_ready) begin
                  armed <= 1'b0;
               end
            end
            ST_H2: begin
               if (bus.tx_ready) seg_cnt <= seg;
            end
            ST_DATA: begin
               if (dat_acc) begin
                  rem     <= rem - 11'd1;
                  addr    <= addr + 7'd1;
                  seg_cnt <= seg_cnt - 10'd1;
                  first   <= 1'b0;
                  if (bus.rd_resp != AXI_OKAY) poison <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // rd_last must coincide with the final expected beat.
   a_last: assert property (@(posedge clk) disable iff (rst)
      dat_acc |-> (bus.rd_last == (rem == 11'd1)));

   // Mid-request splits must land on a completion boundary.
   a_rcb: assert property (@(posedge clk) disable iff (rst)
      (dat_acc && seg_cnt == 10'd1 && rem != 11'd1)
      |-> (((addr + 7'd1) & (cfg_rcb ? 7'h1f : 7'h0f)) == 7'd0));

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_cpl_gen.sv
// Scoreboard bench for the inbound read completion generator.
// Directed requests; a monitor pops expected TLP words on each handshake.
`timescale 1ns/1ps
module tb_dlsc_pcie_s6_inbound_read_cpl_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_rcb;
   logic [2:0]  cfg_max_payload;
   logic [15:0] cfg_completer_id;
   logic        cpl_done;

   dlsc_pcie_s6_inbound_read_cpl_gen_if bus();

   dlsc_pcie_s6_inbound_read_cpl_gen dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus.slave),
      .cfg_rcb          (cfg_rcb),
      .cfg_max_payload  (cfg_max_payload),
      .cfg_completer_id (cfg_completer_id),
      .cpl_done         (cpl_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } word_t;

   beat_t rdq[$];
   word_t expq[$];

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int done_exp = 0;
   int tx_cnt = 0;
   bit thr = 1'b0;
   bit rd_took = 1'b0;

   logic [15:0] r_id;
   logic [7:0]  r_tag;
   logic [2:0]  r_tc;
   logic [1:0]  r_attr;
   int          r_len;
   int          beat_i;
   int          bad_at;
   logic [1:0]  bad_resp;

   function automatic logic [31:0] swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic new_req(input logic [15:0] id, input logic [7:0] tag,
                          input logic [2:0] tc, input logic [1:0] attr,
                          input int len);
      r_id = id; r_tag = tag; r_tc = tc; r_attr = attr;
      r_len = len; beat_i = 0; bad_at = -1; bad_resp = 2'b00;
   endtask

   task automatic push_word(input logic [31:0] d, input logic l);
      word_t w;
      w.d = d;
      w.l = l;
      expq.push_back(w);
   endtask

   task automatic push_beat(output logic [31:0] d);
      beat_t b;
      b.d = $urandom();
      b.r = (beat_i == bad_at) ? bad_resp : 2'b00;
      b.l = (beat_i == r_len - 1);
      rdq.push_back(b);
      d = b.d;
      beat_i++;
   endtask

   task automatic push_seg(input int n, input int bc,
                           input logic [6:0] la, input logic ep);
      logic [31:0] d;
      push_word({1'b0, 2'b10, 5'b01010, 1'b0, r_tc, 4'h0, 1'b0, ep,
                 r_attr, 2'b00, n[9:0]}, 1'b0);
      push_word({cfg_completer_id, 3'b000, 1'b0, bc[11:0]}, 1'b0);
      push_word({r_id, r_tag, 1'b0, la}, 1'b0);
      for (int k = 0; k < n; k++) begin
         push_beat(d);
         push_word(swap(d), k == n - 1);
      end
   endtask

   task automatic push_cpl(input logic [2:0] sts, input int bc,
                           input logic [6:0] la);
      logic [31:0] d;
      push_word({1'b0, 2'b00, 5'b01010, 1'b0, r_tc, 4'h0, 1'b0, 1'b0,
                 r_attr, 2'b00, 10'd0}, 1'b0);
      push_word({cfg_completer_id, sts, 1'b0, bc[11:0]}, 1'b0);
      push_word({r_id, r_tag, 1'b0, la}, 1'b1);
      for (int k = 0; k < r_len; k++) push_beat(d);
   endtask

   task automatic send_req(input logic [6:0] addr, input logic [9:0] len);
      int n;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_id    = r_id;
      bus.req_tag   = r_tag;
      bus.req_tc    = r_tc;
      bus.req_attr  = r_attr;
      bus.req_len   = len;
      bus.req_addr  = addr;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL req_accept timeout got=busy exp=ready");
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while ((expq.size() != 0 || rdq.size() != 0 ||
              done_seen != done_exp) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk({nm, "_cpl_done"}, done_seen, done_exp);
      chk({nm, "_pending"}, expq.size(), 0);
   endtask

   // Read-data source and tx_ready throttle, driven after each edge.
   always @(posedge clk) begin
      #1;
      if (rd_took) begin
         if (rdq.size() > 0) void'(rdq.pop_front());
         bus.rd_valid = 1'b0;
      end
      if (!bus.rd_valid && rdq.size() > 0 &&
          (!thr || $urandom_range(3) != 0)) begin
         bus.rd_valid = 1'b1;
         bus.rd_data  = rdq[0].d;
         bus.rd_resp  = rdq[0].r;
         bus.rd_last  = rdq[0].l;
      end
      bus.tx_ready = !thr || ($urandom_range(3) != 0);
   end

   // Monitor: compare every accepted TLP word against the scoreboard.
   always @(negedge clk) begin
      word_t w;
      rd_took = bus.rd_valid && bus.rd_ready;
      if (!rst) begin
         if (cpl_done) done_seen++;
         if (bus.tx_valid && bus.tx_ready) begin
            tx_cnt++;
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL tx_extra got=%h/%0b exp=none",
                        bus.tx_data, bus.tx_last);
            end else begin
               w = expq.pop_front();
               if ({bus.tx_data, bus.tx_last} !== {w.d, w.l}) begin
                  errors++;
                  $display("FAIL tx_word got=%h/%0b exp=%h/%0b",
                           bus.tx_data, bus.tx_last, w.d, w.l);
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int n;
      bus.req_valid = 1'b0;
      bus.req_id    = '0;
      bus.req_tag   = '0;
      bus.req_tc    = '0;
      bus.req_attr  = '0;
      bus.req_len   = '0;
      bus.req_addr  = '0;
      bus.rd_valid  = 1'b0;
      bus.rd_data   = '0;
      bus.rd_last   = 1'b0;
      bus.rd_resp   = 2'b00;
      bus.tx_ready  = 1'b1;
      cfg_rcb          = 1'b1;
      cfg_max_payload  = 3'd0;
      cfg_completer_id = 16'hBEEF;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_cpl_done", cpl_done, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // 4 DW at 0x00, MPS 128B
      new_req(16'h1234, 8'h01, 3'd0, 2'd0, 4);
      push_seg(4, 16, 7'h00, 1'b0);
      done_exp++;
      send_req(7'h00, 10'd4);
      wait_done("len4");

      // 40 DW at DW 0x1C, MPS 128B: 4/32/4
      new_req(16'h0A0B, 8'h22, 3'd5, 2'd2, 40);
      push_seg(4, 160, 7'h70, 1'b0);
      push_seg(32, 144, 7'h00, 1'b0);
      push_seg(4, 16, 7'h00, 1'b0);
      done_exp++;
      send_req(7'h1C, 10'd40);
      wait_done("len40");

      // DECERR on first beat -> UR, 8 beats drained
      new_req(16'h4321, 8'h33, 3'd1, 2'd1, 8);
      bad_at = 0;
      bad_resp = 2'b11;
      push_cpl(3'b001, 32, 7'h14);
      done_exp++;
      send_req(7'h05, 10'd8);
      wait_done("decerr");

      // SLVERR on first beat -> CA
      cfg_max_payload = 3'd1;
      new_req(16'h5555, 8'h44, 3'd2, 2'd3, 2);
      bad_at = 0;
      bad_resp = 2'b10;
      push_cpl(3'b100, 8, 7'h7C);
      done_exp++;
      send_req(7'h7F, 10'd2);
      wait_done("slverr_first");

      // address wrap at MPS 512B: 2 then 1
      cfg_max_payload = 3'd2;
      new_req(16'h6789, 8'h55, 3'd7, 2'd1, 3);
      push_seg(2, 12, 7'h78, 1'b0);
      push_seg(1, 4, 7'h00, 1'b0);
      done_exp++;
      send_req(7'h7E, 10'd3);
      wait_done("wrap");

      // 64 DW, SLVERR on beat 10 poisons segment 2
      cfg_max_payload = 3'd0;
      new_req(16'h1111, 8'h66, 3'd3, 2'd0, 64);
      bad_at = 10;
      bad_resp = 2'b10;
      push_seg(32, 256, 7'h00, 1'b0);
      push_seg(32, 128, 7'h00, 1'b1);
      done_exp++;
      send_req(7'h00, 10'd64);
      wait_done("poison");

      // 1024 DW at MPS 512B with random throttling
      cfg_max_payload = 3'd2;
      thr = 1'b1;
      new_req(16'h2222, 8'h77, 3'd4, 2'd2, 1024);
      for (int i = 0; i < 8; i++)
         push_seg(128, 4096 - 512 * i, 7'h00, 1'b0);
      done_exp++;
      send_req(7'h00, 10'd0);
      wait_done("len1024");
      thr = 1'b0;

      // reset in the data phase abandons the TLP
      cfg_max_payload = 3'd0;
      new_req(16'h3333, 8'h88, 3'd0, 2'd0, 16);
      push_seg(16, 64, 7'h00, 1'b0);
      tx_cnt = 0;
      send_req(7'h00, 10'd16);
      n = 0;
      while (tx_cnt < 6 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_tlp_reached", (tx_cnt >= 6), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rdq.delete();
      expq.delete();
      bus.rd_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_tx_valid", bus.tx_valid, 0);
      chk("abort_req_ready", bus.req_ready, 1);
      repeat (4) @(negedge clk);
      chk("abort_no_words", expq.size(), 0);

      // request after reset completes normally
      new_req(16'h4444, 8'h99, 3'd6, 2'd3, 4);
      push_seg(4, 16, 7'h0C, 1'b0);
      done_exp++;
      send_req(7'h03, 10'd4);
      wait_done("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
